instr_encoder: RTL and testbench

Instruction encoder and program loader for the toycpu: the write-side counterpart of the instruction decoder. It accepts instruction fields over a valid/ready stream and packs each into a 16-bit toycpu instruction word. It then writes the words to consecutive instruction-memory addresses, one word per cycle. It sits between a host or test source and the instruction-memory write port, and fills program memory before the CPU is released.

---
 rtl/instr_encoder_pkg.sv | 39 +++
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder_pack.sv | 51 +++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// toycpu shared definitions: opcodes, instruction field layout and loader
// FSM states. The decoder imports the same package, so the word layout is
// defined in one place.
package toycpu_pkg;

   localparam logic [2:0] OP_ALU = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_LD  = 3'b011;
   localparam logic [2:0] OP_ST  = 3'b101;
   localparam logic [2:0] OP_BR  = 3'b110;

   localparam int unsigned INSTR_W    = 16;
   localparam int unsigned OP_MSB     = 15;
   localparam int unsigned OP_LSB     = 13;
   localparam int unsigned RD_MSB     = 12;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned RS1_MSB    = 10;
   localparam int unsigned RS1_LSB    = 9;
   localparam int unsigned RS2_MSB    = 8;
   localparam int unsigned RS2_LSB    = 7;
   localparam int unsigned ALU_MSB    = 6;
   localparam int unsigned ALU_LSB    = 0;
   localparam int unsigned IMM_MSB    = 7;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned BR_SEL_BIT = 12;
   localparam int unsigned BR_VAL_BIT = 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } enc_state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op == OP_ALU) || (op == OP_LDI) || (op == OP_LD) ||
             (op == OP_ST)  || (op == OP_BR);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-field beat stream into the encoder (valid/ready).
interface instr_encoder_if;

   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [1:0] in_rd;
   logic [1:0] in_rs1;
   logic [1:0] in_rs2;
   logic [6:0] in_alu_op;
   logic [7:0] in_imm;
   logic       in_br_sel;
   logic       in_br_val;
   logic       in_last;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_alu_op, in_imm,
             in_br_sel, in_br_val, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_alu_op, in_imm,
             in_br_sel, in_br_val, in_last,
      output in_ready
   );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer. Fields an opcode does not use stay 0;
// an illegal opcode yields {op, 13'b0} and raises illegal_o.
module instr_pack
   import toycpu_pkg::*;
(
   input  logic [2:0]         op_i,
   input  logic [1:0]         rd_i,
   input  logic [1:0]         rs1_i,
   input  logic [1:0]         rs2_i,
   input  logic [6:0]         alu_op_i,
   input  logic [7:0]         imm_i,
   input  logic               br_sel_i,
   input  logic               br_val_i,
   output logic [INSTR_W-1:0] word_o,
   output logic               illegal_o
);

   // Place each used field at its package-defined position for the opcode
   always_comb begin
      word_o                 = '0;
      illegal_o              = !op_is_legal(op_i);
      word_o[OP_MSB:OP_LSB]  = op_i;
      case (op_i)
         OP_ALU: begin
            word_o[RD_MSB:RD_LSB]   = rd_i;
            word_o[RS1_MSB:RS1_LSB] = rs1_i;
            word_o[RS2_MSB:RS2_LSB] = rs2_i;
            word_o[ALU_MSB:ALU_LSB] = alu_op_i;
         end
         OP_LDI: begin
            word_o[RD_MSB:RD_LSB]   = rd_i;
            word_o[IMM_MSB:IMM_LSB] = imm_i;
         end
         OP_LD: begin
            word_o[RD_MSB:RD_LSB]   = rd_i;
            word_o[RS1_MSB:RS1_LSB] = rs1_i;
         end
         OP_ST: begin
            word_o[RS1_MSB:RS1_LSB] = rs1_i;
            word_o[RS2_MSB:RS2_LSB] = rs2_i;
         end
         OP_BR: begin
            word_o[BR_SEL_BIT]      = br_sel_i;
            word_o[BR_VAL_BIT]      = br_val_i;
            word_o[IMM_MSB:IMM_LSB] = imm_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs accepted field beats and
// writes them to consecutive instruction-memory addresses, one per cycle.
module instr_encoder
   import toycpu_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   instr_encoder_if.slave      in_s,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [INSTR_W-1:0]  imem_wdata,
   output logic [ADDR_W:0]     count,
   output logic                done,
   output logic                err_illegal,
   output logic                err_full
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP  = '1;

   enc_state_e           state_q;
   logic                 ready_q;
   logic                 we_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [INSTR_W-1:0]   wdata_q;
   logic [ADDR_W-1:0]    ctr_q;
   logic [ADDR_W:0]      count_q;
   logic                 done_q;
   logic                 err_ill_q;
   logic                 err_full_q;

   logic [INSTR_W-1:0]   pack_d;
   logic                 illegal_d;
   logic                 accept_d;
   logic                 at_top_d;
   logic                 final_d;

   instr_pack u_pack (
      .op_i      (in_s.in_op),
      .rd_i      (in_s.in_rd),
      .rs1_i     (in_s.in_rs1),
      .rs2_i     (in_s.in_rs2),
      .alu_op_i  (in_s.in_alu_op),
      .imm_i     (in_s.in_imm),
      .br_sel_i  (in_s.in_br_sel),
      .br_val_i  (in_s.in_br_val),
      .word_o    (pack_d),
      .illegal_o (illegal_d)
   );

   assign accept_d = in_s.in_valid & ready_q;
   assign at_top_d = (ctr_q == TOP);
   assign final_d  = in_s.in_last | at_top_d;

   // Session FSM with counter, write register and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= BASE;
         wdata_q    <= '0;
         ctr_q      <= BASE;
         count_q    <= '0;
         done_q     <= 1'b0;
         err_ill_q  <= 1'b0;
         err_full_q <= 1'b0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q    <= ST_LOAD;
                  ready_q    <= 1'b1;
                  done_q     <= 1'b0;
                  ctr_q      <= BASE;
                  count_q    <= '0;
                  err_ill_q  <= 1'b0;
                  err_full_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept_d) begin
                  we_q    <= 1'b1;
                  addr_q  <= ctr_q;
                  wdata_q <= pack_d;
                  count_q <= count_q + (ADDR_W+1)'(1);
                  if (illegal_d) err_ill_q <= 1'b1;
                  if (at_top_d && !in_s.in_last) err_full_q <= 1'b1;
                  // The counter stops on the final beat so it never wraps.
                  if (final_d) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     ctr_q <= ctr_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_s.in_ready = ready_q;
   assign imem_we       = we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign count         = count_q;
   assign done          = done_q;
   assign err_illegal   = err_ill_q;
   assign err_full      = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: an 8-bit-address instance for the
// encoding and session tests and a 2-bit-address instance for the full case.
module tb_instr_encoder;
   import toycpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start8, start2;
   always #5 clk = ~clk;

   instr_encoder_if if8 ();
   instr_encoder_if if2 ();

   logic        we8, done8, eill8, efull8;
   logic [7:0]  addr8;
   logic [15:0] wdata8;
   logic [8:0]  count8;
   logic        we2, done2, eill2, efull2;
   logic [1:0]  addr2;
   logic [15:0] wdata2;
   logic [2:0]  count2;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .in_s(if8),
      .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8), .count(count8),
      .done(done8), .err_illegal(eill8), .err_full(efull8)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .in_s(if2),
      .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .count(count2),
      .done(done2), .err_illegal(eill2), .err_full(efull2)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];
   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference encoder built from shifts, independent of the packer
   function automatic logic [15:0] model(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2,
                                         input logic [6:0] alu, input logic [7:0] imm,
                                         input logic sel, input logic val);
      logic [15:0] w;
      w = 16'(op) << 13;
      case (op)
         3'd0: w = w | (16'(rd) << 11) | (16'(rs1) << 9) | (16'(rs2) << 7) | 16'(alu);
         3'd1: w = w | (16'(rd) << 11) | 16'(imm);
         3'd3: w = w | (16'(rd) << 11) | (16'(rs1) << 9);
         3'd5: w = w | (16'(rs1) << 9) | (16'(rs2) << 7);
         3'd6: w = w | (16'(sel) << 12) | (16'(val) << 11) | 16'(imm);
         default: ;
      endcase
      return w;
   endfunction

   // Scoreboard monitors: every write must match the oldest expected entry
   always @(negedge clk) begin
      exp_t e;
      if (we8 === 1'b1) begin
         if (q8.size() == 0) check_eq("we8_unexpected", 32'(we8), 32'd0);
         else begin
            e = q8.pop_front();
            check_eq("addr8", 32'(addr8), 32'(e.addr));
            check_eq("wdata8", 32'(wdata8), 32'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (we2 === 1'b1) begin
         if (q2.size() == 0) check_eq("we2_unexpected", 32'(we2), 32'd0);
         else begin
            e = q2.pop_front();
            check_eq("addr2", 32'(addr2), 32'(e.addr));
            check_eq("wdata2", 32'(wdata2), 32'(e.data));
         end
      end
   end

   task automatic set8(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [6:0] alu, input logic [7:0] imm,
                       input logic sel, input logic val, input logic last);
      if8.in_op = op;   if8.in_rd = rd;   if8.in_rs1 = rs1; if8.in_rs2 = rs2;
      if8.in_alu_op = alu; if8.in_imm = imm; if8.in_br_sel = sel;
      if8.in_br_val = val; if8.in_last = last;
   endtask

   // Present one beat, wait (bounded) for ready, push its expectation, accept
   task automatic drive8(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [6:0] alu, input logic [7:0] imm,
                         input logic sel, input logic val, input logic last,
                         input logic [7:0] ea, input logic [15:0] ew);
      exp_t e;
      int unsigned budget;
      set8(op, rd, rs1, rs2, alu, imm, sel, val, last);
      if8.in_valid = 1'b1;
      budget = 0;
      while (if8.in_ready !== 1'b1 && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      if (if8.in_ready !== 1'b1) begin
         check_eq("ready8_timeout", 32'(if8.in_ready), 32'd1);
         if8.in_valid = 1'b0;
         return;
      end
      e.addr = ea;
      e.data = ew;
      q8.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic pulse_start8();
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic check_rst8();
      check_eq("rst_ready8", 32'(if8.in_ready), 32'd0);
      check_eq("rst_we8",    32'(we8),    32'd0);
      check_eq("rst_addr8",  32'(addr8),  32'd0);
      check_eq("rst_wdata8", 32'(wdata8), 32'd0);
      check_eq("rst_count8", 32'(count8), 32'd0);
      check_eq("rst_done8",  32'(done8),  32'd0);
      check_eq("rst_eill8",  32'(eill8),  32'd0);
      check_eq("rst_efull8", 32'(efull8), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [2:0] op;
      logic [1:0] rd, rs1, rs2;
      logic [6:0] alu;
      logic [7:0] imm;
      logic       sel, val, ill_exp;
      exp_t       e;

      rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
      if8.in_valid = 1'b0; set8(3'd0, 2'd0, 2'd0, 2'd0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      if2.in_valid = 1'b0; if2.in_op = '0; if2.in_rd = '0; if2.in_rs1 = '0;
      if2.in_rs2 = '0; if2.in_alu_op = '0; if2.in_imm = '0; if2.in_br_sel = 1'b0;
      if2.in_br_val = 1'b0; if2.in_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_rst8();
      check_eq("rst_ready2", 32'(if2.in_ready), 32'd0);
      check_eq("rst_count2", 32'(count2), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single ALU beat ending a session
      pulse_start8();
      check_eq("ready8_load", 32'(if8.in_ready), 32'd1);
      drive8(OP_ALU, 2'd1, 2'd2, 2'd3, 7'h05, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0D85);
      if8.in_valid = 1'b0;
      @(negedge clk);
      check_eq("alu_done8", 32'(done8), 32'd1);
      check_eq("alu_count8", 32'(count8), 32'd1);

      // Three-beat stream with junk in unused fields, valid held past last
      pulse_start8();
      drive8(OP_LDI, 2'd2, 2'd3, 2'd3, 7'h7F, 8'hA5, 1'b1, 1'b1, 1'b0, 8'd0, 16'h30A5);
      drive8(OP_LD,  2'd3, 2'd2, 2'd1, 7'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd1, 16'h7C00);
      drive8(OP_ST,  2'd3, 2'd1, 2'd2, 7'h2A, 8'h5A, 1'b0, 1'b1, 1'b1, 8'd2, 16'hA300);
      @(negedge clk);
      check_eq("stream_done8",  32'(done8),  32'd1);
      check_eq("stream_count8", 32'(count8), 32'd3);
      check_eq("stream_ready8", 32'(if8.in_ready), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      if8.in_valid = 1'b0;
      check_eq("hold_count8", 32'(count8), 32'd3);

      // Branch, then illegal opcode with all fields set
      pulse_start8();
      check_eq("restart_done8",  32'(done8),  32'd0);
      check_eq("restart_count8", 32'(count8), 32'd0);
      drive8(OP_BR, 2'd3, 2'd3, 2'd3, 7'h7F, 8'h40, 1'b1, 1'b1, 1'b0, 8'd0, 16'hD840);
      drive8(3'b111, 2'd3, 2'd3, 2'd3, 7'h7F, 8'hFF, 1'b1, 1'b1, 1'b1, 8'd1, 16'hE000);
      if8.in_valid = 1'b0;
      @(negedge clk);
      check_eq("ill_eill8",  32'(eill8),  32'd1);
      check_eq("ill_efull8", 32'(efull8), 32'd0);

      // Restart clears the sticky flag, then a random 16-beat stream
      pulse_start8();
      check_eq("clr_eill8", 32'(eill8), 32'd0);
      ill_exp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 7)); rd = 2'($urandom); rs1 = 2'($urandom);
         rs2 = 2'($urandom); alu = 7'($urandom); imm = 8'($urandom);
         sel = 1'($urandom); val = 1'($urandom);
         if (op == 3'd2 || op == 3'd4 || op == 3'd7) ill_exp = 1'b1;
         drive8(op, rd, rs1, rs2, alu, imm, sel, val, (i == 15), 8'(i),
                model(op, rd, rs1, rs2, alu, imm, sel, val));
      end
      if8.in_valid = 1'b0;
      @(negedge clk);
      check_eq("rand_done8",  32'(done8),  32'd1);
      check_eq("rand_count8", 32'(count8), 32'd16);
      check_eq("rand_eill8",  32'(eill8),  32'(ill_exp));

      // Small memory: four beats fill it, the fifth and sixth are refused
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      if2.in_valid = 1'b1;
      if2.in_last  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         op = (i % 2 == 0) ? OP_ALU : OP_LDI;
         rd = 2'(i); rs1 = 2'(i + 1); rs2 = 2'(i + 2);
         alu = 7'(8'h11 * i); imm = 8'(8'h21 * (i + 1));
         if2.in_op = op; if2.in_rd = rd; if2.in_rs1 = rs1; if2.in_rs2 = rs2;
         if2.in_alu_op = alu; if2.in_imm = imm;
         if (i < 4) begin
            e.addr = 8'(i);
            e.data = model(op, rd, rs1, rs2, alu, imm, 1'b0, 1'b0);
            q2.push_back(e);
         end
         @(posedge clk); #1;
      end
      if2.in_valid = 1'b0;
      @(negedge clk);
      check_eq("full_efull2", 32'(efull2), 32'd1);
      check_eq("full_done2",  32'(done2),  32'd1);
      check_eq("full_count2", 32'(count2), 32'd4);
      check_eq("full_ready2", 32'(if2.in_ready), 32'd0);

      // Reset in the cycle after an accepted beat drops the next beat
      pulse_start8();
      set8(OP_ALU, 2'd2, 2'd1, 2'd0, 7'h33, 8'h00, 1'b0, 1'b0, 1'b0);
      if8.in_valid = 1'b1;
      e.addr = 8'd0;
      e.data = 16'h1233;
      q8.push_back(e);
      @(posedge clk); #1;
      rst = 1'b1;
      set8(OP_ALU, 2'd1, 2'd1, 2'd1, 7'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_rst8();
      @(posedge clk); #1;
      rst = 1'b0;
      if8.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("idle_ready8", 32'(if8.in_ready), 32'd0);
      check_eq("idle_count8", 32'(count8), 32'd0);

      check_eq("q8_empty", 32'(q8.size()), 32'd0);
      check_eq("q2_empty", 32'(q2.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
